// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for a dual-write-port 16x16 register file.
// Grants up to two of three requesters per cycle in round-robin order and tracks pending destinations.
module rf_wb_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_dest,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wb_hold,
    input  logic                 alloc_valid,
    input  logic [3:0]           alloc_dest,
    output logic                 regWrite1,
    output logic                 regWrite2,
    output logic [3:0]           destReg1,
    output logic [3:0]           destReg2,
    output logic [15:0]          writeData1,
    output logic [15:0]          writeData2,
    output logic [15:0]          busy
);

    logic [1:0]      rr_ptr_r;
    logic [3:0]      dest_s [NREQ];
    logic [15:0]     data_s [NREQ];
    logic [NREQ-1:0] cand_s;
    logic [1:0]      ord_s [NREQ];
    logic            w1_found_s;
    logic            w2_found_s;
    logic [1:0]      w1_idx_s;
    logic [1:0]      w2_idx_s;
    logic [NREQ-1:0] ready_s;

    logic            we1_r;
    logic            we2_r;
    logic [3:0]      dest1_r;
    logic [3:0]      dest2_r;
    logic [15:0]     data1_r;
    logic [15:0]     data2_r;
    logic [15:0]     busy_r;
    logic [15:0]     set_s;
    logic [15:0]     clr_s;

    function automatic logic [1:0] inc_mod3(input logic [1:0] v);
        case (v)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [NREQ-1:0] idx_onehot(input logic [1:0] idx);
        logic [NREQ-1:0] one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    function automatic logic [15:0] reg_onehot(input logic [3:0] r);
        logic [15:0] one;
        one = 16'h0001;
        return one << r;
    endfunction

    // Unpack the flat request buses into per-requester fields.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            dest_s[i] = req_dest[4*i +: 4];
            data_s[i] = req_data[16*i +: 16];
        end
    end

    // Candidate mask: nothing competes while held or in reset.
    always_comb begin
        if (reset && !wb_hold) begin
            cand_s = req_valid;
        end else begin
            cand_s = {NREQ{1'b0}};
        end
    end

    // Round-robin search; a candidate colliding with W1's destination is passed over so no WAW occurs in one cycle.
    always_comb begin
        logic take1;
        logic take2;
        ord_s[0]   = rr_ptr_r;
        ord_s[1]   = inc_mod3(rr_ptr_r);
        ord_s[2]   = inc_mod3(inc_mod3(rr_ptr_r));
        w1_found_s = 1'b0;
        w2_found_s = 1'b0;
        w1_idx_s   = 2'd0;
        w2_idx_s   = 2'd0;
        for (int p = 0; p < NREQ; p++) begin
            take1 = cand_s[ord_s[p]] && !w1_found_s;
            take2 = cand_s[ord_s[p]] && w1_found_s && !w2_found_s
                    && (dest_s[ord_s[p]] != dest_s[w1_idx_s]);
            w1_idx_s   = take1 ? ord_s[p] : w1_idx_s;
            w2_idx_s   = take2 ? ord_s[p] : w2_idx_s;
            w1_found_s = w1_found_s | take1;
            w2_found_s = w2_found_s | take2;
        end
    end

    // Grant vector from the two winners.
    always_comb begin
        ready_s = {NREQ{1'b0}};
        if (w1_found_s) begin
            ready_s = ready_s | idx_onehot(w1_idx_s);
        end else begin
            ready_s = ready_s;
        end
        if (w2_found_s) begin
            ready_s = ready_s | idx_onehot(w2_idx_s);
        end else begin
            ready_s = ready_s;
        end
    end

    assign req_ready = ready_s;

    // Priority pointer moves just past the port-1 winner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_r <= 2'd0;
        end else if (w1_found_s) begin
            rr_ptr_r <= inc_mod3(w1_idx_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Port 1 register: r0 writes load dest/data but keep the write enable low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we1_r   <= 1'b0;
            dest1_r <= 4'd0;
            data1_r <= 16'h0000;
        end else if (w1_found_s) begin
            we1_r   <= (dest_s[w1_idx_s] != 4'd0);
            dest1_r <= dest_s[w1_idx_s];
            data1_r <= data_s[w1_idx_s];
        end else begin
            we1_r   <= 1'b0;
        end
    end

    // Port 2 register, loaded from the second winner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we2_r   <= 1'b0;
            dest2_r <= 4'd0;
            data2_r <= 16'h0000;
        end else if (w2_found_s) begin
            we2_r   <= (dest_s[w2_idx_s] != 4'd0);
            dest2_r <= dest_s[w2_idx_s];
            data2_r <= data_s[w2_idx_s];
        end else begin
            we2_r   <= 1'b0;
        end
    end

    // Clears come from the loaded ports, so a bit drops only after the register file has written it.
    always_comb begin
        clr_s = 16'h0000;
        if (we1_r) begin
            clr_s = clr_s | reg_onehot(dest1_r);
        end else begin
            clr_s = clr_s;
        end
        if (we2_r) begin
            clr_s = clr_s | reg_onehot(dest2_r);
        end else begin
            clr_s = clr_s;
        end
        if (alloc_valid && (alloc_dest != 4'd0)) begin
            set_s = reg_onehot(alloc_dest);
        end else begin
            set_s = 16'h0000;
        end
    end

    // Scoreboard update; a set on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r <= 16'h0000;
        end else begin
            busy_r <= (busy_r & ~clr_s) | set_s;
        end
    end

    assign regWrite1  = we1_r;
    assign regWrite2  = we2_r;
    assign destReg1   = dest1_r;
    assign destReg2   = dest2_r;
    assign writeData1 = data1_r;
    assign writeData2 = data2_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected port writes go into a queue that a
// negedge monitor drains whenever a regWrite is presented.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [11:0] req_dest;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_hold;
    logic        alloc_valid;
    logic [3:0]  alloc_dest;
    logic        regWrite1, regWrite2;
    logic [3:0]  destReg1, destReg2;
    logic [15:0] writeData1, writeData2;
    logic [15:0] busy;

    typedef struct packed {
        logic [1:0]  port;
        logic [3:0]  dest;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready), .wb_hold(wb_hold),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .regWrite1(regWrite1), .regWrite2(regWrite2),
        .destReg1(destReg1), .destReg2(destReg2),
        .writeData1(writeData1), .writeData2(writeData2),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [1:0] p, input logic [3:0] d, input logic [15:0] x);
        wr_t w;
        w.port = p;
        w.dest = d;
        w.data = x;
        exp_q.push_back(w);
    endtask

    task automatic check_port(input logic [1:0] p, input logic [3:0] d, input logic [15:0] x);
        wr_t w;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL port_unexpected: got port %0d r%0d=%h expected no write", p, d, x);
        end else begin
            w = exp_q.pop_front();
            chk("port_write", {10'd0, p, d, x}, {10'd0, w});
        end
    endtask

    // Monitor: every presented register-file write must match the next expected one.
    always @(negedge clk) begin
        if (regWrite1 === 1'b1) check_port(2'd1, destReg1, writeData1);
        if (regWrite2 === 1'b1) check_port(2'd2, destReg2, writeData2);
    end

    // One cycle: drive at negedge, check grants mid-cycle, return at the next negedge.
    task automatic step(input logic [2:0] v, input logic hold, input logic av,
                        input logic [3:0] ad, input logic [2:0] er, input string name);
        req_valid   = v;
        wb_hold     = hold;
        alloc_valid = av;
        alloc_dest  = ad;
        #1;
        chk({name, "_ready"}, {29'd0, req_ready}, {29'd0, er});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        req_valid   = 3'b000;
        wb_hold     = 1'b0;
        alloc_valid = 1'b0;
        alloc_dest  = 4'd0;
        req_dest    = {4'h7, 4'h5, 4'h3};
        req_data    = {16'h3333, 16'h2222, 16'h1111};
        @(negedge clk);

        // Reset: no grants even with all requesters valid.
        step(3'b111, 1'b0, 1'b0, 4'd0, 3'b000, "rst");
        chk("rst_ports", {22'd0, regWrite1, regWrite2, destReg1, destReg2}, 32'd0);
        chk("rst_data", {writeData1, writeData2}, 32'd0);
        chk("rst_busy", {16'd0, busy}, 32'd0);

        // Three requesters, distinct destinations.
        reset = 1'b1;
        expect_wr(2'd1, 4'd3, 16'h1111);
        expect_wr(2'd2, 4'd5, 16'h2222);
        step(3'b111, 1'b0, 1'b0, 4'd0, 3'b011, "s1_c0");
        expect_wr(2'd1, 4'd7, 16'h3333);
        step(3'b100, 1'b0, 1'b0, 4'd0, 3'b100, "s1_c1");
        step(3'b000, 1'b0, 1'b0, 4'd0, 3'b000, "s1_idle");
        chk("s1_busy", {16'd0, busy}, 32'd0);

        // Same destination: only A this cycle, B next.
        req_dest = {4'h0, 4'h4, 4'h4};
        req_data = {16'h0000, 16'hBBBB, 16'hAAAA};
        expect_wr(2'd1, 4'd4, 16'hAAAA);
        step(3'b011, 1'b0, 1'b0, 4'd0, 3'b001, "s2_c0");
        expect_wr(2'd1, 4'd4, 16'hBBBB);
        step(3'b010, 1'b0, 1'b0, 4'd0, 3'b010, "s2_c1");
        step(3'b000, 1'b0, 1'b0, 4'd0, 3'b000, "s2_idle");
        chk("s2_final", {12'd0, destReg1, writeData1}, {12'd0, 4'h4, 16'hBBBB});

        // Alloc r6, memory unit writes it two cycles later.
        step(3'b000, 1'b0, 1'b1, 4'd6, 3'b000, "s3_alloc");
        chk("s3_busy_set", {16'd0, busy}, {16'd0, 16'h0040});
        step(3'b000, 1'b0, 1'b0, 4'd0, 3'b000, "s3_gap");
        chk("s3_busy_gap", {16'd0, busy}, {16'd0, 16'h0040});
        req_dest = {4'h6, 8'h00};
        req_data = {16'h6666, 32'h0000_0000};
        expect_wr(2'd1, 4'd6, 16'h6666);
        step(3'b100, 1'b0, 1'b0, 4'd0, 3'b100, "s3_wr");
        chk("s3_busy_load", {16'd0, busy}, {16'd0, 16'h0040});
        step(3'b000, 1'b0, 1'b0, 4'd0, 3'b000, "s3_idle");
        chk("s3_busy_clr", {16'd0, busy}, 32'd0);

        // Alloc r9 lands on the same edge as the clear of a granted r9 write.
        step(3'b000, 1'b0, 1'b1, 4'd9, 3'b000, "s4_alloc");
        chk("s4_busy_set", {16'd0, busy}, {16'd0, 16'h0200});
        req_dest = {4'h0, 4'h0, 4'h9};
        req_data = {32'h0000_0000, 16'h9999};
        expect_wr(2'd1, 4'd9, 16'h9999);
        step(3'b001, 1'b0, 1'b0, 4'd0, 3'b001, "s4_wr");
        chk("s4_busy_load", {16'd0, busy}, {16'd0, 16'h0200});
        step(3'b000, 1'b0, 1'b1, 4'd9, 3'b000, "s4_realloc");
        chk("s4_set_wins", {16'd0, busy}, {16'd0, 16'h0200});
        step(3'b000, 1'b0, 1'b0, 4'd0, 3'b000, "s4_idle");
        chk("s4_still_busy", {16'd0, busy}, {16'd0, 16'h0200});
        req_dest = {4'h0, 4'h9, 4'h0};
        req_data = {16'h0000, 16'h9A9A, 16'h0000};
        expect_wr(2'd1, 4'd9, 16'h9A9A);
        step(3'b010, 1'b0, 1'b0, 4'd0, 3'b010, "s4_wr2");
        step(3'b000, 1'b0, 1'b0, 4'd0, 3'b000, "s4_idle2");
        chk("s4_busy_clr", {16'd0, busy}, 32'd0);
        step(3'b000, 1'b0, 1'b1, 4'd0, 3'b000, "s4_alloc_r0");
        chk("s4_alloc_r0", {16'd0, busy}, 32'd0);

        // Write to r0: handshake completes, nothing is written.
        req_dest = 12'h000;
        req_data = {32'h0000_0000, 16'hFFFF};
        step(3'b001, 1'b0, 1'b0, 4'd0, 3'b001, "s5_r0");
        chk("s5_regwrite", {30'd0, regWrite1, regWrite2}, 32'd0);
        chk("s5_port1", {12'd0, destReg1, writeData1}, {12'd0, 4'h0, 16'hFFFF});
        chk("s5_busy", {16'd0, busy}, 32'd0);

        // Pointer at 1: B wins, memory unit collides and is skipped, A takes port 2.
        req_dest = {4'h8, 4'h8, 4'hA};
        req_data = {16'h5252, 16'h5151, 16'h5050};
        expect_wr(2'd1, 4'd8, 16'h5151);
        expect_wr(2'd2, 4'hA, 16'h5050);
        step(3'b111, 1'b0, 1'b0, 4'd0, 3'b011, "s6_c0");
        expect_wr(2'd1, 4'd8, 16'h5252);
        step(3'b100, 1'b0, 1'b0, 4'd0, 3'b100, "s6_c1");
        step(3'b000, 1'b0, 1'b0, 4'd0, 3'b000, "s6_idle");

        // Build busy = 00F0, hold the ports, then reset mid-stream.
        for (int a = 4; a < 8; a++) begin
            step(3'b000, 1'b0, 1'b1, a[3:0], 3'b000, "s7_alloc");
        end
        chk("s7_busy_set", {16'd0, busy}, {16'd0, 16'h00F0});
        req_dest = {4'h3, 4'h2, 4'h1};
        req_data = {16'hC3C3, 16'hC2C2, 16'hC1C1};
        for (int h = 0; h < 4; h++) begin
            step(3'b111, 1'b1, 1'b0, 4'd0, 3'b000, "s7_hold");
            chk("s7_hold_we", {30'd0, regWrite1, regWrite2}, 32'd0);
        end
        chk("s7_busy_hold", {16'd0, busy}, {16'd0, 16'h00F0});
        reset = 1'b0;
        step(3'b111, 1'b0, 1'b0, 4'd0, 3'b000, "s7_rst");
        chk("s7_rst_ports", {22'd0, regWrite1, regWrite2, destReg1, destReg2}, 32'd0);
        chk("s7_rst_data", {writeData1, writeData2}, 32'd0);
        chk("s7_rst_busy", {16'd0, busy}, 32'd0);
        reset = 1'b1;
        expect_wr(2'd1, 4'd1, 16'hC1C1);
        expect_wr(2'd2, 4'd2, 16'hC2C2);
        step(3'b111, 1'b0, 1'b0, 4'd0, 3'b011, "s7_c0");
        expect_wr(2'd1, 4'd3, 16'hC3C3);
        step(3'b100, 1'b0, 1'b0, 4'd0, 3'b100, "s7_c1");
        step(3'b000, 1'b0, 1'b0, 4'd0, 3'b000, "s7_idle");

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
